// File: rtl/tick_timer_pwm.sv
// Tick-driven up/down timer with shadowed period/compare, one-shot mode,
// compare-based PWM, one-cycle update pulse and sticky interrupt flag.
module tick_timer_pwm #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             en,
    input  logic             dir,
    input  logic             one_shot,
    input  logic [WIDTH-1:0] arr,
    input  logic [WIDTH-1:0] ccr,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             pwm,
    output logic             ovf,
    output logic             irq,
    output logic             running
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] arr_sh;
    logic [WIDTH-1:0] ccr_sh;
    logic             upd;

    // Update event: a counted tick that hits the end of the period in the current direction.
    always_comb begin
        upd = 1'b0;
        if (state == RUN && en && tick)
            upd = dir ? (cnt == '0) : (cnt == arr_sh);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            ovf    <= 1'b0;
            irq    <= 1'b0;
            arr_sh <= '0;
            ccr_sh <= '0;
        end else begin
            ovf <= upd;
            if (upd)
                irq <= 1'b1;
            else if (irq_clr)
                irq <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en) begin
                        state  <= RUN;
                        arr_sh <= arr;
                        ccr_sh <= ccr;
                        cnt    <= dir ? arr : '0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (upd) begin
                            // Down-count reload takes the freshly shadowed period.
                            arr_sh <= arr;
                            ccr_sh <= ccr;
                            cnt    <= dir ? arr : '0;
                            if (one_shot)
                                state <= DONE;
                        end else begin
                            cnt <= dir ? cnt - WIDTH'(1) : cnt + WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    if (!en) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign running = (state == RUN);
    assign pwm     = running && (cnt < ccr_sh);

endmodule
